// File: rtl/simd_proc_frontend_if.sv
// Issuer-facing handshake and local data-memory port of one SIMD lane front end.
interface simd_proc_frontend_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int COUNT_W   = 8,
  parameter int OP_W      = 2,
  parameter int PAYLOAD_W = COUNT_W + OP_W + ADDR_W
);
  logic                 i_en;
  logic                 i_valid;
  logic [PAYLOAD_W+1:0] i_instr;
  logic                 o_ack;
  logic                 o_busy;
  logic                 o_finish;
  logic                 i_finish_ack;
  logic                 o_proto_err;
  logic                 o_mem_rd_en;
  logic [ADDR_W-1:0]    o_mem_rd_addr;
  logic [DATA_W-1:0]    i_mem_rd_data;
  logic                 o_mem_wr_en;
  logic [ADDR_W-1:0]    o_mem_wr_addr;
  logic [DATA_W-1:0]    o_mem_wr_data;

  // issuer plus memory side
  modport master (
    output i_en, i_valid, i_instr, i_finish_ack, i_mem_rd_data,
    input  o_ack, o_busy, o_finish, o_proto_err,
           o_mem_rd_en, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
  );

  // lane front end side
  modport slave (
    input  i_en, i_valid, i_instr, i_finish_ack, i_mem_rd_data,
    output o_ack, o_busy, o_finish, o_proto_err,
           o_mem_rd_en, o_mem_rd_addr, o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
  );
endinterface

// File: rtl/simd_proc_frontend.sv
// SIMD lane front end: takes LD/LD/INFO from the issuer, runs `count`
// element-wise ops (read A, read B, write f(A,B)), then holds finish until acked.
module simd_proc_frontend #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int COUNT_W   = 8,
  parameter int OP_W      = 2,
  parameter int PAYLOAD_W = COUNT_W + OP_W + ADDR_W
) (
  input logic               i_clk,
  input logic               i_rstn,
  simd_proc_frontend_if.slave bus
);

  localparam logic [1:0] TYPE_LD   = 2'b01;
  localparam logic [1:0] TYPE_INFO = 2'b10;

  // IDLE doubles as GET_LD1: the first LD is only taken there while i_en is high
  typedef enum logic [2:0] {IDLE, GET_LD2, GET_INFO, RD_A, RD_B, WR, FINISH} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr0, addr0_nx, addr1, addr1_nx, wr_base, wr_base_nx;
  logic [COUNT_W-1:0]  count, count_nx, idx, idx_nx;
  logic [OP_W-1:0]     op, op_nx;
  logic [DATA_W-1:0]   a_val, a_nx, result;
  logic                ack, ack_nx, busy, finish, proto_err, err_nx;
  logic                rd_en, rd_en_nx, wr_en, wr_en_nx;
  logic [ADDR_W-1:0]   rd_addr, rd_addr_nx, wr_addr, wr_addr_nx;

  logic [1:0]           itype;
  logic [PAYLOAD_W-1:0] payload;
  logic                 take;

  assign itype   = bus.i_instr[PAYLOAD_W +: 2];
  assign payload = bus.i_instr[PAYLOAD_W-1:0];
  // an ack cycle never accepts, so an instruction still held from the last accept is ignored
  assign take    = bus.i_valid && !ack;

  // state, latched job fields and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= IDLE;
      addr0     <= '0;
      addr1     <= '0;
      wr_base   <= '0;
      count     <= '0;
      idx       <= '0;
      op        <= '0;
      a_val     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      finish    <= 1'b0;
      proto_err <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_nx;
      addr0     <= addr0_nx;
      addr1     <= addr1_nx;
      wr_base   <= wr_base_nx;
      count     <= count_nx;
      idx       <= idx_nx;
      op        <= op_nx;
      a_val     <= a_nx;
      ack       <= ack_nx;
      busy      <= (state_nx != IDLE);
      finish    <= (state_nx == FINISH);
      proto_err <= err_nx;
      rd_en     <= rd_en_nx;
      rd_addr   <= rd_addr_nx;
      wr_en     <= wr_en_nx;
      wr_addr   <= wr_addr_nx;
    end
  end

  // next state, field latching and the strobes for the state being entered
  always_comb begin
    state_nx   = state;
    addr0_nx   = addr0;
    addr1_nx   = addr1;
    wr_base_nx = wr_base;
    count_nx   = count;
    idx_nx     = idx;
    op_nx      = op;
    a_nx       = a_val;
    ack_nx     = 1'b0;
    err_nx     = proto_err;
    rd_en_nx   = 1'b0;
    rd_addr_nx = rd_addr;
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr;
    case (state)
      IDLE: begin
        if (bus.i_en && take) begin
          if (itype == TYPE_LD) begin
            addr0_nx = payload[ADDR_W-1:0];
            ack_nx   = 1'b1;
            state_nx = GET_LD2;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      GET_LD2: begin
        if (take) begin
          if (itype == TYPE_LD) begin
            addr1_nx = payload[ADDR_W-1:0];
            ack_nx   = 1'b1;
            state_nx = GET_INFO;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      GET_INFO: begin
        if (take) begin
          if (itype == TYPE_INFO) begin
            count_nx   = payload[ADDR_W+OP_W +: COUNT_W];
            op_nx      = payload[ADDR_W +: OP_W];
            wr_base_nx = payload[ADDR_W-1:0];
            idx_nx     = '0;
            ack_nx     = 1'b1;
            if (payload[ADDR_W+OP_W +: COUNT_W] != '0) begin
              state_nx   = RD_A;
              rd_en_nx   = 1'b1;
              rd_addr_nx = addr0;
            end else begin
              state_nx = FINISH;
            end
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      RD_A: begin
        state_nx   = RD_B;
        rd_en_nx   = 1'b1;
        rd_addr_nx = addr1 + ADDR_W'(idx);
      end
      RD_B: begin
        // A was read in RD_A and lands now; B lands during WR
        state_nx   = WR;
        a_nx       = bus.i_mem_rd_data;
        wr_en_nx   = 1'b1;
        wr_addr_nx = wr_base + ADDR_W'(idx);
      end
      WR: begin
        // idx < count here, so idx+1 cannot overflow
        idx_nx = idx + 1'b1;
        if (idx_nx < count) begin
          state_nx   = RD_A;
          rd_en_nx   = 1'b1;
          rd_addr_nx = addr0 + ADDR_W'(idx_nx);
        end else begin
          state_nx = FINISH;
        end
      end
      FINISH: begin
        if (bus.i_finish_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // element op; B only arrives during WR, so write data is formed from the
  // registered A/op and the live read data rather than registered itself
  always_comb begin
    result = a_val;
    case (op)
      OP_W'(0): result = a_val + bus.i_mem_rd_data;
      OP_W'(1): result = a_val - bus.i_mem_rd_data;
      OP_W'(2): result = a_val * bus.i_mem_rd_data;
      default:  result = a_val;
    endcase
  end

  assign bus.o_ack         = ack;
  assign bus.o_busy        = busy;
  assign bus.o_finish      = finish;
  assign bus.o_proto_err   = proto_err;
  assign bus.o_mem_rd_en   = rd_en;
  assign bus.o_mem_rd_addr = rd_addr;
  assign bus.o_mem_wr_en   = wr_en;
  assign bus.o_mem_wr_addr = wr_addr;
  assign bus.o_mem_wr_data = wr_en ? result : '0;

endmodule
